fetch_ctrl: RTL
===============

# fetch_ctrl

Sequencing controller for the instruction fetch stage of the 64-bit RISC-V pipeline. It owns the program counter and drives the instruction-memory address. It loads the fetched word into a registered IF/ID output with a valid/ready handshake toward decode. It resolves redirects from execute, stall back-pressure from decode, halt/resume requests and misaligned-target errors.

## Interface
Parameters:
- RESET_PC, 64'h0, byte address of the first instruction fetched after reset; must be 4-aligned
- NOP_INSTR, 32'h00000013, value held on if_instr whenever if_valid is 0

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  64  byte address to instruction memory, equal to the internal pc
- imem_rdata  in  32  instruction word; combinational, valid in the same cycle as imem_addr
- if_valid  out  1  IF/ID register holds an instruction
- if_pc  out  64  byte address of if_instr
- if_instr  out  32  fetched instruction
- id_ready  in  1  decode accepts if_* this cycle
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  64  redirect target byte address
- halt_req  in  1  stop fetching, sampled in RUN
- resume  in  1  restart fetching, sampled in HALTED
- halted  out  1  state is HALTED
- misalign_err  out  1  sticky; a redirect target had bits [1:0] not equal to 0
- fetch_count  out  32  number of instructions handed to decode

## Operation
- States: IDLE, RUN, HALTED, ERROR.
- Reset values:
  - state IDLE, pc = RESET_PC
  - if_valid 0, if_pc 0, if_instr NOP_INSTR
  - halted 0, misalign_err 0, fetch_count 0
- IDLE: no capture. Unconditionally moves to RUN on the next edge.
- Handshake: the transfer is complete when if_valid && id_ready. fetch_count increments by 1 on each transfer and wraps at 2^32.
- RUN has the following priority per edge, highest first:
  1. redirect_valid with redirect_pc[1:0] != 0:
     - go to ERROR
     - misalign_err <= 1, if_valid <= 0
     - pc unchanged
  2. redirect_valid with an aligned target:
     - pc <= redirect_pc
     - if_valid <= 0 (flush), if_instr <= NOP_INSTR
     - no capture
     - if halt_req is also 1, go to HALTED with pc = redirect_pc
  3. halt_req:
     - go to HALTED, no capture
     - an occupied output register stays valid until it transfers, then clears
     - pc unchanged
  4. Output register free (!if_valid or id_ready):
     - if_valid <= 1, if_pc <= pc, if_instr <= imem_rdata
     - pc <= pc + 4
  5. Otherwise (stall): pc and if_* hold.
- HALTED:
  - never captures; halted = 1
  - an aligned redirect updates pc and stays HALTED; a misaligned redirect goes to ERROR
  - resume goes to RUN, with the first capture on the following edge
- ERROR:
  - if_valid 0, no capture
  - all inputs except reset are ignored; only reset exits
- Arithmetic: pc + 4 is modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. No flag is raised.
- Reset mid-operation:
  - an in-flight if_valid is dropped
  - the count is cleared
  - state returns to IDLE regardless of the current state

## Timing
- First fetch:
  - edge E0 has reset = 1
  - edge E1 has reset = 0: IDLE to RUN
  - edge E2: capture at RESET_PC, so if_valid = 1 after E2
- Steady state: one instruction per cycle while id_ready = 1. Fetch-to-output latency is 1 edge.
- Redirect costs exactly one bubble cycle: the target is captured on the edge after redirect_valid.
- Stall: if_* stay stable while if_valid && !id_ready.
- halted and misalign_err are registered and assert after the transition edge.

## Structure
- Shared package fetch_pkg:
  - state enum (IDLE, RUN, HALTED, ERROR)
  - NOP_INSTR constant
  - XLEN = 64 and ILEN = 32 constants
- One sub-module, fetch_out_reg: the IF/ID holding register, with load/flush/hold controls and valid, pc and instr fields.
- The next-pc mux and state machine live in fetch_ctrl.

## Test plan
- Reset release with RESET_PC = 0x100 and id_ready = 1 → if_pc = 0x100, 0x104, 0x108 on consecutive cycles starting 2 edges after reset drops. fetch_count = 3 after the third transfer.
- id_ready held 0 for 3 cycles while if_valid → if_pc/if_instr stable; pc not advanced; fetch_count unchanged. The next transfer delivers the held instruction, then the next pc.
- redirect_valid with redirect_pc = 0x2000 while stalled at 0x108 → if_valid 0 for one cycle, then if_pc = 0x2000; 0x108 never transfers.
- halt_req together with redirect 0x40 → halted = 1, no new valid. resume → next capture has if_pc = 0x40.
- redirect_pc = 0x2002 → misalign_err = 1 and state ERROR; resume and redirects are ignored; reset clears everything.
- pc = 0xFFFF_FFFF_FFFF_FFFC captured → next if_pc = 0x0 with no error.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// IF/ID holding register: flush empties it, load captures a new word, otherwise it holds.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP_VALUE = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [ILEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] instr
);

  // Flush beats load so a redirect can never let a wrong-path word through.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_VALUE;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_VALUE;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the pc, picks the next pc and drives the IF/ID register.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  import fetch_pkg::*;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            out_load, out_flush, set_err;
  logic            transfer, redirect_bad, redirect_ok;

  assign transfer     = if_valid && id_ready;
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign imem_addr    = pc;
  assign halted       = (state == HALTED);

  // State, pc, sticky error and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (set_err) misalign_err <= 1'b1;
      if (transfer) fetch_count <= fetch_count + 32'd1;
    end
  end

  // Next-state, next-pc and output-register control in per-state priority order.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    out_load   = 1'b0;
    out_flush  = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        state_next = RUN;
      end
      RUN: begin
        if (redirect_bad) begin
          state_next = ERROR;
          set_err    = 1'b1;
          out_flush  = 1'b1;
        end else if (redirect_ok) begin
          pc_next    = redirect_pc;
          out_flush  = 1'b1;
          if (halt_req) state_next = HALTED;
        end else if (halt_req) begin
          state_next = HALTED;
          if (transfer) out_flush = 1'b1;
        end else if (!if_valid || id_ready) begin
          out_load = 1'b1;
          pc_next  = pc + 64'd4;
        end
      end
      HALTED: begin
        if (transfer) out_flush = 1'b1;
        if (redirect_bad) begin
          state_next = ERROR;
          set_err    = 1'b1;
          out_flush  = 1'b1;
        end else if (redirect_ok) begin
          pc_next = redirect_pc;
        end else if (resume) begin
          state_next = RUN;
        end
      end
      ERROR: begin
        out_flush = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  fetch_out_reg #(
    .NOP_VALUE(NOP_INSTR)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .flush     (out_flush),
    .load_pc   (pc),
    .load_instr(imem_rdata),
    .valid     (if_valid),
    .pc        (if_pc),
    .instr     (if_instr)
  );

endmodule
